// File: rtl/display_7segment_scanner_pkg.sv
// Shared definitions for the 7-segment scanner: blank pattern, FSM state
// encoding and the hex-to-segment table (common-anode, active-low,
// bit order {dp,g,f,e,d,c,b,a}).
package display_7segment_scanner_pkg;

   // All segments and the decimal point off on a common-anode display
   localparam logic [7:0] SEG_OFF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   // Hex digit to active-low segment pattern, decimal point always off
   function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
      logic [7:0] seg;
      case (hex)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/display_7segment_scanner_decoder.sv
// Combinational hex to 7-segment decoder shared by all digits of the scanner.
module decoderDisplay7Segment
   import display_7segment_scanner_pkg::*;
(
   output logic [7:0] o,
   input  logic [3:0] i
);

   // Pure table lookup; the scanner registers the result
   always_comb begin
      o = hex_to_seg(i);
   end

endmodule

// File: rtl/display_7segment_scanner.sv
// Time-multiplexed NUM_DIGITS-digit 7-segment driver with an anti-ghost blank
// gap per digit slot and frame-aligned (tear-free) commit of new values.
// Optional build macro: DISPLAY_7SEG_LEADING_ZERO_BLANK_EN blanks leading
// zero digits (digit 0 is never blanked).
module display_7segment_scanner
   import display_7segment_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic [7:0]              seg_out,
   output logic                    update_pend,
   output logic                    frame_tick
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("NUM_DIGITS must be in 2..8");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
   end

   state_e                  state_q;
   logic [IW-1:0]           idx_q;
   logic [CW-1:0]           cnt_q;
   logic [4*NUM_DIGITS-1:0] shadow_q;
   logic [4*NUM_DIGITS-1:0] active_q;
   logic                    pend_q;
   logic [NUM_DIGITS-1:0]   dig_en_q;
   logic [7:0]              seg_q;
   logic                    tick_q;

   logic                    slot_last;
   logic                    blank_last;
   logic                    frame_wrap;
   logic                    commit;
   logic [3:0]              nibble_sel;
   logic [7:0]              seg_dec;
   logic [7:0]              seg_show_d;
   logic [NUM_DIGITS-1:0]   dig_sel;

   // Slot timing and frame boundary / commit qualification
   always_comb begin
      slot_last  = (cnt_q == CNT_LAST);
      blank_last = (cnt_q == BLANK_LAST);
      frame_wrap = disp_en && (state_q == ST_SHOW) && slot_last && (idx_q == IDX_LAST);
      commit     = pend_q && ((disp_en && (state_q == ST_IDLE)) || frame_wrap);
   end

   // SHOW is only ever entered or held with idx_q unchanged and no commit on
   // that edge, so decoding active_q at idx_q gives the pattern for the next cycle
   always_comb begin
      nibble_sel = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (IW'(k) == idx_q) begin
            nibble_sel = active_q[4*k +: 4];
         end
      end
   end

   decoderDisplay7Segment u_decoder (
      .o (seg_dec),
      .i (nibble_sel)
   );

`ifdef DISPLAY_7SEG_LEADING_ZERO_BLANK_EN
   logic upper_zero;

   // Blank a digit when it and every more significant digit are zero
   always_comb begin
      upper_zero = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if ((IW'(k) >= idx_q) && (active_q[4*k +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
      end
      seg_show_d = ((idx_q != '0) && upper_zero) ? SEG_OFF : seg_dec;
   end
`else
   // Every digit shows its decoded nibble, zeros included
   always_comb begin
      seg_show_d = seg_dec;
   end
`endif

   // One-hot strobe for the current digit
   always_comb begin
      dig_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
   end

   // Scan FSM with registered digit/segment outputs and frame tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         dig_en_q <= '0;
         seg_q    <= SEG_OFF;
         tick_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (!disp_en) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dig_en_q <= '0;
            seg_q    <= SEG_OFF;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q  <= ST_BLANK;
                  idx_q    <= '0;
                  cnt_q    <= '0;
                  dig_en_q <= '0;
                  seg_q    <= SEG_OFF;
               end
               ST_BLANK: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (blank_last) begin
                     state_q  <= ST_SHOW;
                     dig_en_q <= dig_sel;
                     seg_q    <= seg_show_d;
                  end else begin
                     dig_en_q <= '0;
                     seg_q    <= SEG_OFF;
                  end
               end
               ST_SHOW: begin
                  if (slot_last) begin
                     state_q  <= ST_BLANK;
                     cnt_q    <= '0;
                     dig_en_q <= '0;
                     seg_q    <= SEG_OFF;
                     if (idx_q == IDX_LAST) begin
                        idx_q  <= '0;
                        tick_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     cnt_q    <= cnt_q + 1'b1;
                     dig_en_q <= dig_sel;
                     seg_q    <= seg_show_d;
                  end
               end
               default: begin
                  state_q  <= ST_IDLE;
                  idx_q    <= '0;
                  cnt_q    <= '0;
                  dig_en_q <= '0;
                  seg_q    <= SEG_OFF;
               end
            endcase
         end
      end
   end

   // Double buffer: commit uses the pre-edge shadow, so a coincident load
   // lands in the shadow and keeps the pending flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         if (commit) begin
            active_q <= shadow_q;
         end
         if (load) begin
            shadow_q <= data_in;
            pend_q   <= 1'b1;
         end else if (commit) begin
            pend_q <= 1'b0;
         end
      end
   end

   assign dig_en      = dig_en_q;
   assign seg_out     = seg_q;
   assign update_pend = pend_q;
   assign frame_tick  = tick_q;

endmodule

// File: tb/tb_display_7segment_scanner.sv
// Scoreboard bench for display_7segment_scanner (NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2). Expected per-cycle outputs are queued with a cycle stamp;
// a negedge monitor pops and compares them.
module tb_display_7segment_scanner;

   logic        clk;
   logic        rst_n;
   logic        disp_en;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dig_en;
   logic [7:0]  seg_out;
   logic        update_pend;
   logic        frame_tick;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [3:0] dig;
      logic [7:0] seg;
      logic       pend;
      logic       tick;
      bit         tick_dc;
      string      name;
   } exp_t;

   exp_t sb[$];

   localparam int F0 = 8;
   localparam int F1 = F0 + 32;
   localparam int F2 = F1 + 32;
   localparam int F3 = F2 + 32;
   localparam int F4 = F3 + 32;
   localparam int G0 = F4 + 24;
   localparam int H0 = G0 + 13;
   localparam int H1 = H0 + 32;

`ifdef DISPLAY_7SEG_LEADING_ZERO_BLANK_EN
   localparam logic [31:0] SEGS_0000 = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
   localparam logic [31:0] SEGS_0050 = {8'hFF, 8'hFF, 8'h92, 8'hC0};
`else
   localparam logic [31:0] SEGS_0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
   localparam logic [31:0] SEGS_0050 = {8'hC0, 8'hC0, 8'h92, 8'hC0};
`endif

   display_7segment_scanner #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_en     (disp_en),
      .load        (load),
      .data_in     (data_in),
      .dig_en      (dig_en),
      .seg_out     (seg_out),
      .update_pend (update_pend),
      .frame_tick  (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic push(input int at, input logic [3:0] dig, input logic [7:0] seg,
                       input logic pend, input logic tick, input bit dc, input string name);
      exp_t e;
      e.cyc = at; e.dig = dig; e.seg = seg; e.pend = pend;
      e.tick = tick; e.tick_dc = dc; e.name = name;
      sb.push_back(e);
   endtask

   task automatic push_off(input int from, input int to, input logic pend, input string name);
      for (int c = from; c <= to; c++) push(c, 4'b0000, 8'hFF, pend, 1'b0, 1'b0, name);
   endtask

   // segs = {digit3, digit2, digit1, digit0}; pend is 1 for frame offsets lo..hi-1
   task automatic push_frame(input int f0, input int n, input logic [31:0] segs,
                             input int lo, input int hi, input logic tick0,
                             input bit dc0, input string name);
      for (int k = 0; k < n; k++) begin
         int d;
         int pos;
         logic [3:0] dg;
         logic [7:0] sg;
         d   = k / 8;
         pos = k % 8;
         if (pos < 2) begin
            dg = 4'b0000;
            sg = 8'hFF;
         end else begin
            dg = 4'b0001 << d;
            sg = segs[8*d +: 8];
         end
         push(f0 + k, dg, sg, (k >= lo) && (k < hi), (k == 0) ? tick0 : 1'b0,
              (k == 0) && dc0, name);
      end
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare the scoreboard entry stamped with the current cycle
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: cycle %0d expectation never compared (now %0d)", e.name, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if (dig_en !== e.dig || seg_out !== e.seg || update_pend !== e.pend ||
             (!e.tick_dc && frame_tick !== e.tick)) begin
            errors++;
            $display("FAIL %s cyc %0d: got dig_en=%b seg_out=%h pend=%b tick=%b, want dig_en=%b seg_out=%h pend=%b tick=%b%s",
                     e.name, cyc, dig_en, seg_out, update_pend, frame_tick,
                     e.dig, e.seg, e.pend, e.tick, e.tick_dc ? "(dc)" : "");
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      disp_en = 1'b1;
      load    = 1'b1;
      data_in = 16'hFFFF;

      // Expected response for the whole run, in cycle order
      push_off(1, 4, 1'b0, "reset_hold");
      push_off(5, 6, 1'b0, "idle");
      push(7, 4'b0000, 8'hFF, 1'b1, 1'b0, 1'b0, "load_pend");
      push_frame(F0, 32, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 0, 0, 1'b0, 1'b1, "scan_1234");
      push_frame(F1, 32, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 11, 32, 1'b1, 1'b0, "tearfree_old");
      push_frame(F2, 32, {8'h88, 8'h83, 8'hC6, 8'hA1}, 6, 32, 1'b1, 1'b0, "scan_ABCD");
      push_frame(F3, 32, {8'h90, 8'h90, 8'h90, 8'h90}, 0, 32, 1'b1, 1'b0, "simul_9999");
      push_frame(F4, 20, {8'h92, 8'h92, 8'h92, 8'h92}, 0, 0, 1'b1, 1'b0, "scan_5555");
      push_off(F4 + 20, F4 + 23, 1'b0, "disabled");
      push_frame(G0, 10, {8'h92, 8'h92, 8'h92, 8'h92}, 4, 10, 1'b0, 1'b0, "reenable");
      push_off(G0 + 10, G0 + 12, 1'b0, "reset_mid");
      push_frame(H0, 32, SEGS_0000, 6, 32, 1'b0, 1'b0, "after_reset");
      push_frame(H1, 32, SEGS_0050, 0, 0, 1'b1, 1'b0, "lead_zero_0050");

      // Stimulus
      tick_to(4);
      rst_n = 1'b1; disp_en = 1'b0; load = 1'b0; data_in = 16'h0000;
      tick_to(6);
      load = 1'b1; data_in = 16'h1234;
      tick_to(7);
      load = 1'b0; disp_en = 1'b1;
      tick_to(F1 + 10);
      load = 1'b1; data_in = 16'hABCD;
      tick_to(F1 + 11);
      load = 1'b0;
      tick_to(F2 + 5);
      load = 1'b1; data_in = 16'h9999;
      tick_to(F2 + 6);
      load = 1'b0;
      tick_to(F3 - 1);
      load = 1'b1; data_in = 16'h5555;
      tick_to(F3);
      load = 1'b0;
      tick_to(F4 + 19);
      disp_en = 1'b0;
      tick_to(F4 + 23);
      disp_en = 1'b1;
      tick_to(G0 + 3);
      load = 1'b1; data_in = 16'h7777;
      tick_to(G0 + 4);
      load = 1'b0;
      tick_to(G0 + 10);
      rst_n = 1'b0;
      tick_to(G0 + 12);
      rst_n = 1'b1;
      tick_to(H0 + 5);
      load = 1'b1; data_in = 16'h0050;
      tick_to(H0 + 6);
      load = 1'b0;
      tick_to(H1 + 33);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
